imem_arbiter: RTL and testbench

- Owns the single instruction-memory port and shares it between two requesters:
  - the 2-wide fetch unit (fire-and-forget request pulses, no ready signal);
  - a loader/debug port that can read or write one word.
- Buffers fetch requests in a small queue and back-pressures fetch with a stall.
- Allows one memory transaction in flight and squashes fetch responses made stale by a redirect.
- Sits between the fetch stage and the imem model/controller.

---
 rtl/core_pkg.sv | 23 ++
 rtl/imem_req_fifo.sv | 70 +++++++
 rtl/imem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package core_pkg;

    localparam int XLEN         = 32;
    localparam int FQ_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        F_WAIT,
        D_WAIT
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DBG
    } grant_t;

    typedef struct packed {
        logic [XLEN-1:0] addr0;
        logic [XLEN-1:0] addr1;
    } fetch_req_t;

endpackage

// File: rtl/imem_req_fifo.sv
// Small synchronous FIFO for pending fetch requests; flush beats push.
module imem_req_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              din,
    output T              dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    T              mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single imem port between queued fetch pairs and a loader/debug
// port, one transaction in flight, with redirect squash and a watchdog.
module imem_arbiter
    import core_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DEF,
    parameter int TIMEOUT  = 64,
    parameter int TO_W     = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_en,
    input  logic              f_ren,
    input  logic [XLEN-1:0]   f_addr0,
    input  logic [XLEN-1:0]   f_addr1,
    output logic              fetch_stall,
    output logic              imem_valid,
    output logic [2*XLEN-1:0] imem_pc,
    output logic [XLEN-1:0]   imem_rdata0,
    output logic [XLEN-1:0]   imem_rdata1,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [XLEN-1:0]   dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr0,
    output logic [XLEN-1:0]   mem_addr1,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata0,
    input  logic [XLEN-1:0]   mem_rdata1,
    output logic              err_timeout
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    fetch_req_t    push_req, head_req;
    logic [CW-1:0] fq_count;
    logic          fq_empty, fq_full, fq_pop;

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              squash_q, squash_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic              dbg_wr_q, dbg_wr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr0_q, mem_addr0_d;
    logic [XLEN-1:0]   mem_addr1_q, mem_addr1_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              dbg_gnt_q, dbg_gnt_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic              imem_valid_q, imem_valid_d;
    logic [2*XLEN-1:0] imem_pc_q, imem_pc_d;
    logic [XLEN-1:0]   imem_rdata0_q, imem_rdata0_d;
    logic [XLEN-1:0]   imem_rdata1_q, imem_rdata1_d;

    assign push_req = '{addr0: f_addr0, addr1: f_addr1};

    imem_req_fifo #(
        .DEPTH (FQ_DEPTH),
        .T     (fetch_req_t)
    ) u_fq (
        .clk   (clk),
        .reset (reset),
        .push  (f_ren),
        .pop   (fq_pop),
        .flush (redirect_en),
        .din   (push_req),
        .dout  (head_req),
        .count (fq_count),
        .empty (fq_empty),
        .full  (fq_full)
    );

    // One slot of slack: fetch issues a cycle after it sees the stall.
    assign fetch_stall = (fq_count >= CW'(FQ_DEPTH - 1));

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        squash_d      = squash_q;
        wd_d          = wd_q;
        err_d         = err_q;
        dbg_wr_d      = dbg_wr_q;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr0_d   = mem_addr0_q;
        mem_addr1_d   = mem_addr1_q;
        mem_wdata_d   = mem_wdata_q;
        dbg_gnt_d     = 1'b0;
        dbg_rvalid_d  = 1'b0;
        dbg_rdata_d   = dbg_rdata_q;
        imem_valid_d  = 1'b0;
        imem_pc_d     = imem_pc_q;
        imem_rdata0_d = imem_rdata0_q;
        imem_rdata1_d = imem_rdata1_q;
        fq_pop        = 1'b0;

        if (redirect_en && state_q == F_WAIT) squash_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (!fq_empty && !redirect_en && (!dbg_req || last_grant_q == GNT_DBG)) begin
                    fq_pop       = 1'b1;
                    state_d      = F_WAIT;
                    mem_req_d    = 1'b1;
                    mem_addr0_d  = head_req.addr0;
                    mem_addr1_d  = head_req.addr1;
                    last_grant_d = GNT_FETCH;
                end else if (dbg_req && (fq_empty || last_grant_q == GNT_FETCH)) begin
                    state_d      = D_WAIT;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dbg_we;
                    mem_addr0_d  = dbg_addr;
                    mem_addr1_d  = dbg_addr + XLEN'(4);
                    mem_wdata_d  = dbg_wdata;
                    dbg_wr_d     = dbg_we;
                    dbg_gnt_d    = 1'b1;
                    last_grant_d = GNT_DBG;
                end
            end
            F_WAIT, D_WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    wd_d    = '0;
                    if (state_q == F_WAIT) begin
                        squash_d = 1'b0;
                        if (!squash_q && !redirect_en) begin
                            imem_valid_d  = 1'b1;
                            imem_pc_d     = {mem_addr0_q, mem_addr1_q};
                            imem_rdata0_d = mem_rdata0;
                            imem_rdata1_d = mem_rdata1;
                        end
                    end else begin
                        dbg_rvalid_d = 1'b1;
                        dbg_rdata_d  = dbg_wr_q ? '0 : mem_rdata0;
                    end
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    wd_d     = '0;
                    err_d    = 1'b1;
                    squash_d = 1'b0;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GNT_DBG;
            squash_q      <= 1'b0;
            wd_q          <= '0;
            err_q         <= 1'b0;
            dbg_wr_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr0_q   <= '0;
            mem_addr1_q   <= '0;
            mem_wdata_q   <= '0;
            dbg_gnt_q     <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            dbg_rdata_q   <= '0;
            imem_valid_q  <= 1'b0;
            imem_pc_q     <= '0;
            imem_rdata0_q <= '0;
            imem_rdata1_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            squash_q      <= squash_d;
            wd_q          <= wd_d;
            err_q         <= err_d;
            dbg_wr_q      <= dbg_wr_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr0_q   <= mem_addr0_d;
            mem_addr1_q   <= mem_addr1_d;
            mem_wdata_q   <= mem_wdata_d;
            dbg_gnt_q     <= dbg_gnt_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            dbg_rdata_q   <= dbg_rdata_d;
            imem_valid_q  <= imem_valid_d;
            imem_pc_q     <= imem_pc_d;
            imem_rdata0_q <= imem_rdata0_d;
            imem_rdata1_q <= imem_rdata1_d;
        end
    end

    assign imem_valid  = imem_valid_q;
    assign imem_pc     = imem_pc_q;
    assign imem_rdata0 = imem_rdata0_q;
    assign imem_rdata1 = imem_rdata1_q;
    assign dbg_gnt     = dbg_gnt_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr0   = mem_addr0_q;
    assign mem_addr1   = mem_addr1_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_timeout = err_q;

    a_push_full: assert property (@(posedge clk) disable iff (reset)
        !(f_ren && !redirect_en && fq_full));

    a_rvalid_idle: assert property (@(posedge clk) disable iff (reset)
        !(mem_rvalid && state_q == IDLE));

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: expected issues/responses are queued at
// stimulus time and retired by a negedge monitor.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_en, f_ren;
    logic [31:0] f_addr0, f_addr1;
    logic        fetch_stall, imem_valid;
    logic [63:0] imem_pc;
    logic [31:0] imem_rdata0, imem_rdata1;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr0, mem_addr1, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata0, mem_rdata1;
    logic        err_timeout;

    imem_arbiter dut (
        .clk(clk), .reset(reset), .redirect_en(redirect_en),
        .f_ren(f_ren), .f_addr0(f_addr0), .f_addr1(f_addr1),
        .fetch_stall(fetch_stall), .imem_valid(imem_valid), .imem_pc(imem_pc),
        .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_dbg;
        logic        we;
        logic [31:0] a0, a1, wd;
    } iss_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] d0, d1;
    } fresp_t;

    iss_t        iss_q[$];
    fresp_t      f_sb[$];
    logic [31:0] d_sb[$];

    int n_chk = 0;
    int n_err = 0;
    int n_imem = 0, n_gnt = 0, n_drv = 0;
    logic        resp_mute = 1'b0;
    logic [31:0] r_a0, r_a1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory contents as seen by the responder.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return 32'hAAAA0000 + (a >> 2) - 32'd63;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic exp_fetch(input logic [31:0] a0, input logic [31:0] a1, input bit served);
        iss_q.push_back('{is_dbg: 1'b0, we: 1'b0, a0: a0, a1: a1, wd: 32'h0});
        if (served) f_sb.push_back('{pc: {a0, a1}, d0: rd_fn(a0), d1: rd_fn(a1)});
    endtask

    task automatic exp_dbg(input logic we, input logic [31:0] a, input logic [31:0] wd);
        iss_q.push_back('{is_dbg: 1'b1, we: we, a0: a, a1: a + 32'd4, wd: wd});
        d_sb.push_back(we ? 32'h0 : rd_fn(a));
    endtask

    task automatic do_fetch(input logic [31:0] a0, input logic [31:0] a1, input bit served);
        exp_fetch(a0, a1, served);
        f_ren   = 1'b1;
        f_addr0 = a0;
        f_addr1 = a1;
        tick();
        f_ren = 1'b0;
    endtask

    task automatic wait_mem_req(input string tag);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) begin
                seen = 1;
                break;
            end
        end
        chk(tag, seen, 1);
    endtask

    task automatic wait_gnt(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (dbg_gnt) begin
                seen = 1;
                break;
            end
        end
        dbg_req = 1'b0;
        chk(tag, seen, 1);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_iss_empty"}, iss_q.size(), 0);
        chk({tag, "_f_sb_empty"}, f_sb.size(), 0);
        chk({tag, "_d_sb_empty"}, d_sb.size(), 0);
    endtask

    // Memory model: completes 2 cycles after each request unless muted.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata0 = '0;
        mem_rdata1 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && mem_req && !resp_mute) begin
                r_a0 = mem_addr0;
                r_a1 = mem_addr1;
                repeat (2) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata0 = rd_fn(r_a0);
                mem_rdata1 = rd_fn(r_a1);
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        iss_t   ie;
        fresp_t fe;
        logic [31:0] de;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_req) begin
                    chk("mem_req_expected", iss_q.size() > 0, 1);
                    if (iss_q.size() > 0) begin
                        ie = iss_q.pop_front();
                        chk("mem_addr0", mem_addr0, ie.a0);
                        chk("mem_addr1", mem_addr1, ie.a1);
                        chk("mem_we", mem_we, ie.we);
                        chk("dbg_gnt_on_issue", dbg_gnt, ie.is_dbg);
                        if (ie.we) chk("mem_wdata", mem_wdata, ie.wd);
                    end
                end
                if (dbg_gnt) begin
                    n_gnt++;
                    chk("dbg_gnt_with_req", mem_req, 1);
                end
                if (imem_valid) begin
                    n_imem++;
                    chk("imem_valid_expected", f_sb.size() > 0, 1);
                    if (f_sb.size() > 0) begin
                        fe = f_sb.pop_front();
                        chk("imem_pc", imem_pc, fe.pc);
                        chk("imem_rdata0", imem_rdata0, fe.d0);
                        chk("imem_rdata1", imem_rdata1, fe.d1);
                    end
                end
                if (dbg_rvalid) begin
                    n_drv++;
                    chk("dbg_rvalid_expected", d_sb.size() > 0, 1);
                    if (d_sb.size() > 0) begin
                        de = d_sb.pop_front();
                        chk("dbg_rdata", dbg_rdata, de);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int g0, r0, i0;
        reset       = 1'b1;
        redirect_en = 1'b0;
        f_ren       = 1'b0;
        f_addr0     = '0;
        f_addr1     = '0;
        dbg_req     = 1'b0;
        dbg_we      = 1'b0;
        dbg_addr    = '0;
        dbg_wdata   = '0;
        run(3);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_imem_valid", imem_valid, 0);
        chk("rst_fetch_stall", fetch_stall, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_imem_pc", imem_pc, 0);
        reset = 1'b0;
        run(2);

        // single fetch
        do_fetch(32'h100, 32'h104, 1);
        chk("t1_stall_after_push", fetch_stall, 1);
        run(10);
        chk("t1_imem_count", n_imem, 1);
        chk("t1_stall_idle", fetch_stall, 0);
        chk_drained("t1");

        // back-to-back fetches
        do_fetch(32'h0, 32'h4, 1);
        chk("t2_stall_after_push", fetch_stall, 1);
        do_fetch(32'h8, 32'hC, 1);
        chk("t2_stall_second", fetch_stall, 1);
        run(16);
        chk("t2_imem_count", n_imem, 3);
        chk_drained("t2");

        // redirect squashes the in-flight fetch
        do_fetch(32'h40, 32'h44, 0);
        wait_mem_req("t3_req_seen");
        redirect_en = 1'b1;
        tick();
        redirect_en = 1'b0;
        run(8);
        chk("t3_no_imem", n_imem, 3);
        chk("t3_stall_empty", fetch_stall, 0);
        do_fetch(32'h200, 32'h204, 1);
        run(10);
        chk("t3_after_redirect", n_imem, 4);
        chk_drained("t3");

        // debug write
        g0 = n_gnt;
        r0 = n_drv;
        exp_dbg(1'b1, 32'h10, 32'hDEADBEEF);
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 32'h10;
        dbg_wdata = 32'hDEADBEEF;
        wait_gnt("t5_gnt_seen");
        run(8);
        chk("t5_gnt_once", n_gnt - g0, 1);
        chk("t5_rvalid_once", n_drv - r0, 1);
        chk_drained("t5");

        // fetch/debug alternation; last grant was debug so fetch goes first
        g0 = n_gnt;
        r0 = n_drv;
        i0 = n_imem;
        do_fetch(32'h300, 32'h304, 1);
        exp_dbg(1'b0, 32'h80, 32'h0);
        exp_fetch(32'h308, 32'h30C, 1);
        dbg_req   = 1'b1;
        dbg_we    = 1'b0;
        dbg_addr  = 32'h80;
        dbg_wdata = 32'h12345678;
        f_ren     = 1'b1;
        f_addr0   = 32'h308;
        f_addr1   = 32'h30C;
        tick();
        f_ren = 1'b0;
        wait_gnt("t4_gnt_seen");
        run(14);
        chk("t4_gnt_once", n_gnt - g0, 1);
        chk("t4_rvalid_once", n_drv - r0, 1);
        chk("t4_fetch_count", n_imem - i0, 2);
        chk_drained("t4");

        // watchdog
        resp_mute = 1'b1;
        i0 = n_imem;
        do_fetch(32'h500, 32'h504, 0);
        wait_mem_req("t6_req_seen");
        run(62);
        chk("t6_err_before", err_timeout, 0);
        run(3);
        chk("t6_err_after", err_timeout, 1);
        resp_mute = 1'b0;
        do_fetch(32'h600, 32'h604, 1);
        run(10);
        chk("t6_recover", n_imem - i0, 1);
        chk("t6_err_sticky", err_timeout, 1);
        chk_drained("t6");

        reset = 1'b1;
        #3;
        chk("t6_err_reset", err_timeout, 0);
        chk("t6_stall_reset", fetch_stall, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
